imem_responder: RTL and testbench
=================================

# imem_responder

Memory-side responder for the instruction-cache refill path. It accepts line-refill requests from the I-cache miss FSM via a level chip-select, waits a fixed access latency, and then streams one cache line as a burst of words. It also provides the active-low test/initialisation port that the FSM startup sequence uses to write and read back a calibration word. It sits between the I-cache FSM/datapath and the instruction SRAM model. The SRAM array is internal to this block.

## Interface
Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width.
- DEPTH, 256, memory depth in words; must be a power of two.
- BURST_LEN, 4, words per cache line; must be a power of two, 2..16.
- LATENCY, 13, wait cycles from request acceptance to the first data word; legal range 1..15.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_csb  in  1  refill request; active-high level; held by the requester for the whole transfer.
- req_addr  in  ADDR_W  byte address of the missed fetch; sampled when a request is accepted.
- test_en  in  1  test port enable, active-low.
- test_we  in  1  test write strobe; effective only when test_en=0.
- test_addr  in  ADDR_W  test byte address.
- test_wdata  in  DATA_W  test write data.
- test_rdata  out  DATA_W  registered test readback.
- rdata  out  DATA_W  burst data word.
- rvalid  out  1  rdata is valid this cycle.
- rlast  out  1  marks the last word of the burst; asserted only together with rvalid.
- busy  out  1  high while in WAIT, BURST or HOLD.

## Operation
- Word index = byte address >> 2, taken modulo DEPTH (wraps silently). Line base = word index with the low log2(BURST_LEN) bits cleared.
- The state machine has four states: IDLE, WAIT, BURST, HOLD.
- IDLE:
  - Accept a request when mem_csb=1: latch the line base, clear the counter, go to WAIT.
  - Test port in IDLE:
    - test_en=0 and test_we=1: write test_wdata to mem[test index].
    - test_en=0 (with or without test_we): test_rdata <= mem[test index], returning old data on a write to the same address.
    - test_en=1: test_rdata holds its value.
  - The test port is ignored in all other states, and test_rdata holds there.
  - If mem_csb=1 and test_en=0 in the same IDLE cycle, the refill request wins and the test access is dropped.
- WAIT:
  - The 4-bit counter increments each cycle.
  - When the counter reaches LATENCY-1: clear it, go to BURST.
- BURST:
  - Each cycle output word mem[line base + beat] with rvalid=1; the beat counter increments.
  - Words are issued in ascending order from the line base, without critical-word-first.
  - rlast=1 on beat BURST_LEN-1, then go to HOLD.
- HOLD: wait for mem_csb=0, then go to IDLE. The requester may keep mem_csb high for several cycles after rlast; no new request is accepted until mem_csb drops.
- Abort: mem_csb=0 sampled in WAIT or BURST means go to IDLE on that edge, with rvalid/rlast low from the next cycle. A partial burst is not resumed.
- rdata is registered and holds its last value when rvalid=0.

## Timing
- Reset values:
  - state IDLE, both counters 0;
  - rvalid 0, rlast 0, busy 0;
  - rdata 0, test_rdata 0.
  - Memory contents are not reset.
- Reset asserted mid-burst kills the transfer immediately (asynchronous). After release, the block is in IDLE and requires mem_csb to be sampled again.
- Request handshake: mem_csb is sampled high at edge k while in IDLE.
  - busy=1 from k+1.
  - First rvalid in the cycle after edge k+LATENCY+1.
  - Words then appear on BURST_LEN consecutive cycles.
  - Total occupancy from acceptance to rlast is LATENCY+BURST_LEN cycles.
- HOLD lasts at least one cycle. With mem_csb low, the earliest next acceptance is 2 edges after the rlast cycle.
- Test read latency is 1 cycle (registered).
- busy is a registered function of state, with no combinational path from mem_csb.

## Test plan
- Init via test port: in IDLE with test_en=0, write addresses 0x0..0xC with 0x11,0x22,0x33,0x44, then read 0x4 -> test_rdata=0x22 one cycle later. Then test_en=1 -> test_rdata holds 0x22.
- Refill, LATENCY=13, BURST_LEN=4: mem_csb=1 with req_addr=0x8 -> rvalid first high 14 cycles after acceptance. rdata sequence is 0x11,0x22,0x33,0x44 with rlast on 0x44, and busy stays high until mem_csb drops.
- Abort: drop mem_csb during WAIT cycle 5 -> no rvalid ever, IDLE next cycle. Repeat the abort after the second burst word -> rvalid stops after 2 words and rlast is never seen.
- Held request: keep mem_csb=1 for 6 cycles after rlast -> exactly one burst, no re-trigger. Drop then raise mem_csb -> a new burst is accepted.
- Address wrap: DEPTH=256, req_addr=0x3FC plus test-port write of 0xFFFFFFFF at 0x3F0 -> burst covers words 252..255 and the first word is 0xFFFFFFFF. req_addr=0x400 aliases to line 0.
- Reset mid-burst: assert rst at beat 2 -> rvalid, rlast, busy, rdata =0 immediately. Memory contents are preserved, checked by a test-port read after reset.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder for I-cache refills: fixed-latency line burst
// plus an active-low test port used to initialise and read back the SRAM.
module imem_responder #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int BURST_LEN = 4,
  parameter int LATENCY   = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_csb,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              test_en,
  input  logic              test_we,
  input  logic [ADDR_W-1:0] test_addr,
  input  logic [DATA_W-1:0] test_wdata,
  output logic [DATA_W-1:0] test_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              rlast,
  output logic              busy
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BEAT_W = $clog2(BURST_LEN);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, HOLD} state_t;

  state_t            state, next_state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  req_idx, test_idx, line_base, rd_idx;
  logic [3:0]        wait_cnt;
  logic [BEAT_W-1:0] beat;
  logic              test_wr;
  logic              unused_bits;

  // Byte address to word index; upper bits alias modulo DEPTH.
  assign req_idx  = req_addr[IDX_W+1:2];
  assign test_idx = test_addr[IDX_W+1:2];
  assign rd_idx   = line_base + IDX_W'(beat);
  assign unused_bits = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0],
                         test_addr[ADDR_W-1:IDX_W+2], test_addr[1:0]};

  // A refill request in the same IDLE cycle wins over the test port.
  assign test_wr = (state == IDLE) && !mem_csb && !test_en && test_we;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (mem_csb) next_state = WAIT;
      WAIT:  if (!mem_csb)                        next_state = IDLE;
             else if (wait_cnt == 4'(LATENCY-1))  next_state = BURST;
      BURST: if (!mem_csb)                        next_state = IDLE;
             else if (beat == BEAT_W'(BURST_LEN-1)) next_state = HOLD;
      HOLD:  if (!mem_csb) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid     <= 1'b0;
      rlast      <= 1'b0;
      rdata      <= '0;
      test_rdata <= '0;
      wait_cnt   <= '0;
      beat       <= '0;
      line_base  <= '0;
    end else begin
      rvalid <= 1'b0;
      rlast  <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_csb) begin
            line_base <= req_idx & ~IDX_W'(BURST_LEN-1);
            wait_cnt  <= '0;
            beat      <= '0;
          end else if (!test_en) begin
            test_rdata <= mem[test_idx];
          end
        end
        WAIT: if (mem_csb)
          wait_cnt <= (wait_cnt == 4'(LATENCY-1)) ? 4'd0 : wait_cnt + 4'd1;
        BURST: if (mem_csb) begin
          rdata  <= mem[rd_idx];
          rvalid <= 1'b1;
          rlast  <= (beat == BEAT_W'(BURST_LEN-1));
          beat   <= beat + BEAT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Array is not reset; readers above see pre-write data on a same-address write.
  always_ff @(posedge clk) begin
    if (test_wr) mem[test_idx] <= test_wdata;
  end
endmodule

// File: tb/tb_imem_responder.sv
// Randomised bench for imem_responder against a cycle-count reference model.
module tb_imem_responder;
  localparam int L = 13, B = 4, D = 256;

  logic        clk = 1'b0, rst, mem_csb, test_en, test_we;
  logic [31:0] req_addr, test_addr, test_wdata, test_rdata, rdata;
  logic        rvalid, rlast, busy;

  logic [31:0] model [D];
  logic [31:0] exp_rdata, exp_trd;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  imem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(D), .BURST_LEN(B), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .mem_csb(mem_csb), .req_addr(req_addr),
    .test_en(test_en), .test_we(test_we), .test_addr(test_addr), .test_wdata(test_wdata),
    .test_rdata(test_rdata), .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % D);
  endfunction

  task automatic twr(input logic [31:0] a, input logic [31:0] d, input bit verify);
    int i;
    i = widx(a);
    test_en = 1'b0; test_we = 1'b1; test_addr = a; test_wdata = d;
    tick;
    exp_trd = model[i];
    if (verify) chk("twr_old", test_rdata, exp_trd);
    model[i] = d;
    test_en = 1'b1; test_we = 1'b0;
  endtask

  task automatic trd(input logic [31:0] a);
    test_en = 1'b0; test_we = 1'b0; test_addr = a;
    tick;
    exp_trd = model[widx(a)];
    chk("trd", test_rdata, exp_trd);
    test_en = 1'b1;
  endtask

  task automatic thold;
    test_en = 1'b1; test_we = 1'($urandom); test_addr = $urandom; test_wdata = $urandom;
    tick;
    chk("thold", test_rdata, exp_trd);
    test_we = 1'b0;
  endtask

  // Request at address a, mem_csb dropped after observing cycle d (s counts
  // edges since acceptance, s=0 right after the accepting edge).
  task automatic refill(input logic [31:0] a, input int d, input bit noise);
    int i, base;
    bit bz, rv, rl;
    i = widx(a);
    base = i - (i % B);
    chk("pre_busy", 32'(busy), 32'd0);
    mem_csb = 1'b1; req_addr = a;
    if (noise) begin
      test_en = 1'b0; test_we = 1'b1; test_addr = $urandom; test_wdata = $urandom;
    end
    for (int s = 0; s <= d + 1; s++) begin
      tick;
      bz = (s <= d);
      rv = (s >= L + 1) && (s <= L + B) && (s <= d);
      rl = rv && (s == L + B);
      if (rv) exp_rdata = model[base + s - L - 1];
      chk("busy", 32'(busy), 32'(bz));
      chk("rvalid", 32'(rvalid), 32'(rv));
      chk("rlast", 32'(rlast), 32'(rl));
      chk("rdata", rdata, exp_rdata);
      chk("trd_hold", test_rdata, exp_trd);
      if (s == d) begin
        mem_csb = 1'b0; test_en = 1'b1; test_we = 1'b0;
      end else if (noise) begin
        test_en = 1'($urandom); test_we = 1'b1; test_addr = $urandom; test_wdata = $urandom;
      end
    end
    req_addr = $urandom;
  endtask

  task automatic reset_mid_burst(input logic [31:0] a);
    mem_csb = 1'b1; req_addr = a;
    for (int s = 0; s <= L + 2; s++) tick;
    chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_trd", test_rdata, 32'd0);
    mem_csb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = '0; exp_trd = '0;
    tick;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_rvalid", 32'(rvalid), 32'd0);
    for (int k = 0; k < B; k++) trd(a + 32'(4 * k));
  endtask

  initial begin
    rst = 1'b1; mem_csb = 1'b0; test_en = 1'b1; test_we = 1'b0;
    req_addr = '0; test_addr = '0; test_wdata = '0;
    exp_rdata = '0; exp_trd = '0;
    repeat (2) tick;
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_rlast", 32'(rlast), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_trd", test_rdata, 32'd0);
    rst = 1'b0;
    tick;

    for (int k = 0; k < D; k++) twr(32'(4 * k), $urandom, 1'b0);
    trd(32'h0);

    twr(32'h0, 32'h11, 1'b1);
    twr(32'h4, 32'h22, 1'b1);
    twr(32'h8, 32'h33, 1'b1);
    twr(32'hC, 32'h44, 1'b1);
    trd(32'h4);
    chk("init_rd_22", test_rdata, 32'h22);
    thold;
    thold;

    refill(32'h8, L + B + 1, 1'b0);
    chk("burst_last_44", rdata, 32'h44);
    refill(32'h8, 5, 1'b0);
    refill(32'h8, L + 2, 1'b0);
    chk("abort_rdata_22", rdata, 32'h22);
    refill(32'h8, L + B + 6, 1'b0);
    refill(32'h8, L + B, 1'b0);

    twr(32'h3F0, 32'hFFFF_FFFF, 1'b1);
    refill(32'h3FC, L + 1, 1'b0);
    chk("wrap_first", rdata, 32'hFFFF_FFFF);
    refill(32'h400, L + B, 1'b0);
    chk("alias_line0", rdata, 32'h44);

    reset_mid_burst(32'h8);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: twr($urandom, $urandom, 1'b1);
        1: trd($urandom);
        2: thold;
        default: refill($urandom, int'($urandom_range(0, L + B + 4)), 1'($urandom));
      endcase
    end
    for (int k = 0; k < 8; k++) trd($urandom);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
